// File: rtl/conway_pattern_loader.sv
// Coordinate FIFO and load-address replayer feeding the conway grid core.
// Optional out-of-range filtering and drop_count port: define LOADER_BOUNDS_CHECK_EN.
module conway_pattern_loader #(
  parameter int unsigned GRID_ROWS  = 256,
  parameter int unsigned GRID_COLS  = 256,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_addr,
  input  logic             in_last,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             load_ready,
  output logic [15:0]      addr,
  output logic             addr_valid,
  output logic             state,
  output logic [CNT_W-1:0] cell_count
`ifdef LOADER_BOUNDS_CHECK_EN
  ,
  output logic [CNT_W-1:0] drop_count
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    LOAD,
    DRAIN,
    ARMED,
    RUN
  } fsm_t;

  fsm_t        fsm, fsm_nxt;
  logic [15:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic        in_hs, in_range, push, pop, xfer;
  logic        run_latch;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign in_hs    = in_valid && in_ready;
  assign in_range = ({24'd0, in_addr[15:8]} < GRID_ROWS) &&
                    ({24'd0, in_addr[7:0]}  < GRID_COLS);

`ifdef LOADER_BOUNDS_CHECK_EN
  assign push = in_hs && in_range;
`else
  logic unused_range;
  assign unused_range = in_range;
  assign push = in_hs;
`endif

  assign xfer = addr_valid && load_ready;
  // Refill the output register whenever it is empty or being drained this edge.
  assign pop  = !fifo_empty && (!addr_valid || xfer);

  always_comb begin
    fsm_nxt  = fsm;
    in_ready = 1'b0;
    state    = 1'b0;
    case (fsm)
      LOAD: begin
        in_ready = !fifo_full;
        if (in_hs && in_last) fsm_nxt = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty && !addr_valid) fsm_nxt = ARMED;
      end
      ARMED: begin
        if (run_latch || run_req) fsm_nxt = RUN;
      end
      RUN: begin
        state = 1'b1;
        if (halt_req) fsm_nxt = LOAD;
      end
      default: fsm_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fsm <= LOAD;
    else      fsm <= fsm_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_latch <= 1'b0;
    end else if (fsm == ARMED && fsm_nxt == RUN) begin
      run_latch <= 1'b0;
    end else if (run_req && (fsm == LOAD || fsm == DRAIN)) begin
      run_latch <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr       <= '0;
      addr_valid <= 1'b0;
    end else if (pop) begin
      addr       <= mem[rd_ptr[AW-1:0]];
      addr_valid <= 1'b1;
    end else if (xfer) begin
      addr_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cell_count <= '0;
    end else if (fsm == RUN && halt_req) begin
      cell_count <= '0;
    end else if (xfer && cell_count != '1) begin
      cell_count <= cell_count + 1'b1;
    end
  end

`ifdef LOADER_BOUNDS_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_count <= '0;
    end else if (in_hs && !in_range && drop_count != '1) begin
      drop_count <= drop_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_conway_pattern_loader.sv
// Directed bench for conway_pattern_loader: glider table plus hand-written corner sequences.
module tb_conway_pattern_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [15:0] in_addr;
  logic        run_req, halt_req, load_ready;
  logic [15:0] addr;
  logic        addr_valid, state;
  logic [15:0] cell_count;
`ifdef LOADER_BOUNDS_CHECK_EN
  logic [15:0] drop_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] got[$];

  always #5 clk = ~clk;

  conway_pattern_loader #(
    .GRID_ROWS (16),
    .GRID_COLS (256),
    .FIFO_DEPTH(8),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_last   (in_last),
    .run_req   (run_req),
    .halt_req  (halt_req),
    .load_ready(load_ready),
    .addr      (addr),
    .addr_valid(addr_valid),
    .state     (state),
    .cell_count(cell_count)
`ifdef LOADER_BOUNDS_CHECK_EN
    ,
    .drop_count(drop_count)
`endif
  );

  // Record each output transfer that the coming rising edge will complete.
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (addr_valid && state) begin
        errors++;
        $display("FAIL core_contract addr_valid=%b state=%b required no overlap", addr_valid, state);
      end
      if (addr_valid && load_ready) got.push_back(addr);
    end
  end

  typedef struct {
    logic        v;
    logic [15:0] a;
    logic        last;
    logic        rr;
    logic        lr;
    logic        exp_av;
    logic [15:0] exp_addr;
    logic        exp_state;
    logic        exp_rdy;
    logic [15:0] exp_cc;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    in_addr    = '0;
    run_req    = 1'b0;
    halt_req   = 1'b0;
    load_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    got.delete();
  endtask

  task automatic send_beat(input logic [15:0] a, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_addr  = a;
    in_last  = last;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("send_beat_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget, input string nm);
    int k = 0;
    while (got.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(nm, 32'(got.size()), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [15:0] glider[5];
    int          nexp;

    tbl[0] = '{1'b1, 16'h0200, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'd0};
    tbl[1] = '{1'b1, 16'h0102, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0200, 1'b0, 1'b1, 16'd0};
    tbl[2] = '{1'b1, 16'h0202, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0102, 1'b0, 1'b1, 16'd1};
    tbl[3] = '{1'b1, 16'h0302, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0202, 1'b0, 1'b1, 16'd2};
    tbl[4] = '{1'b1, 16'h0301, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0302, 1'b0, 1'b0, 16'd3};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0301, 1'b0, 1'b0, 16'd4};
    tbl[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0301, 1'b0, 1'b0, 16'd5};
    tbl[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0301, 1'b0, 1'b0, 16'd5};
    tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0301, 1'b1, 1'b0, 16'd5};
    tbl[9] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0301, 1'b1, 1'b0, 16'd5};
    glider = '{16'h0200, 16'h0102, 16'h0202, 16'h0302, 16'h0301};

    // Reset state
    do_reset();
    chk("rst_addr_valid", 32'(addr_valid), 32'd0);
    chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cell_count", 32'(cell_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef LOADER_BOUNDS_CHECK_EN
    chk("rst_drop_count", 32'(drop_count), 32'd0);
`endif

    // Glider, cycle by cycle
    for (int i = 0; i < 10; i++) begin
      in_valid   = tbl[i].v;
      in_addr    = tbl[i].a;
      in_last    = tbl[i].last;
      run_req    = tbl[i].rr;
      load_ready = tbl[i].lr;
      step();
      chk($sformatf("glider_av[%0d]", i), 32'(addr_valid), 32'(tbl[i].exp_av));
      chk($sformatf("glider_addr[%0d]", i), 32'(addr), 32'(tbl[i].exp_addr));
      chk($sformatf("glider_state[%0d]", i), 32'(state), 32'(tbl[i].exp_state));
      chk($sformatf("glider_rdy[%0d]", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
      chk($sformatf("glider_cc[%0d]", i), 32'(cell_count), 32'(tbl[i].exp_cc));
    end
    in_valid = 1'b0;
    run_req  = 1'b0;
    chk("glider_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < got.size()) chk($sformatf("glider_order[%0d]", i), 32'(got[i]), 32'(glider[i]));

    // Halt with simultaneous run_req, then a fresh 2-beat pattern
    halt_req = 1'b1;
    run_req  = 1'b1;
    step();
    halt_req = 1'b0;
    run_req  = 1'b0;
    chk("halt_state", 32'(state), 32'd0);
    chk("halt_cc", 32'(cell_count), 32'd0);
    chk("halt_in_ready", 32'(in_ready), 32'd1);
    got.delete();
    send_beat(16'h0A0B, 1'b0);
    send_beat(16'h0C0D, 1'b1);
    wait_got(2, 20, "halt_reload_count");
    if (got.size() >= 2) begin
      chk("halt_reload_0", 32'(got[0]), 32'h0A0B);
      chk("halt_reload_1", 32'(got[1]), 32'h0C0D);
    end
    repeat (4) step();
    chk("halt_no_stale_run", 32'(state), 32'd0);
    chk("halt_reload_cc", 32'(cell_count), 32'd2);

    // Backpressure: 8 FIFO entries plus the output register
    do_reset();
    for (int i = 0; i < 9; i++) send_beat(16'h0100 + 16'(i), 1'b0);
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_addr  = 16'h0109;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp_stall_rdy[%0d]", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp_stall_av[%0d]", i), 32'(addr_valid), 32'd1);
      chk($sformatf("bp_stall_addr[%0d]", i), 32'(addr), 32'h0100);
    end
    load_ready = 1'b1;
    send_beat(16'h0109, 1'b1);
    wait_got(10, 40, "bp_count");
    for (int i = 0; i < 10; i++)
      if (i < got.size()) chk($sformatf("bp_order[%0d]", i), 32'(got[i]), 32'h0100 + 32'(i));
    repeat (2) step();
    chk("bp_cc", 32'(cell_count), 32'd10);

    // Early run request during LOAD
    do_reset();
    load_ready = 1'b1;
    send_beat(16'h0505, 1'b0);
    run_req = 1'b1;
    step();
    run_req = 1'b0;
    chk("early_state0", 32'(state), 32'd0);
    chk("early_av0", 32'(addr_valid), 32'd1);
    chk("early_addr0", 32'(addr), 32'h0505);
    send_beat(16'h0606, 1'b1);
    chk("early_av1", 32'(addr_valid), 32'd0);
    chk("early_state1", 32'(state), 32'd0);
    step();
    chk("early_av2", 32'(addr_valid), 32'd1);
    chk("early_addr2", 32'(addr), 32'h0606);
    step();
    chk("early_av3", 32'(addr_valid), 32'd0);
    chk("early_state3", 32'(state), 32'd0);
    step();
    chk("early_state_armed", 32'(state), 32'd0);
    step();
    chk("early_state_run", 32'(state), 32'd1);
    chk("early_cc", 32'(cell_count), 32'd2);
    chk("early_in_ready_run", 32'(in_ready), 32'd0);

    // Out-of-range row followed by an in-range one
    do_reset();
    load_ready = 1'b1;
    send_beat(16'h1003, 1'b0);
`ifdef LOADER_BOUNDS_CHECK_EN
    chk("bounds_drop1", 32'(drop_count), 32'd1);
    nexp = 1;
`else
    nexp = 2;
`endif
    step();
`ifdef LOADER_BOUNDS_CHECK_EN
    chk("bounds_no_av", 32'(addr_valid), 32'd0);
`else
    chk("bounds_av", 32'(addr_valid), 32'd1);
`endif
    send_beat(16'h0F03, 1'b1);
    wait_got(nexp, 20, "bounds_count");
    if (got.size() >= 1) chk("bounds_last_addr", 32'(got[got.size()-1]), 32'h0F03);

    // Asynchronous reset while draining
    do_reset();
    load_ready = 1'b1;
    send_beat(16'h0011, 1'b0);
    send_beat(16'h0022, 1'b0);
    send_beat(16'h0033, 1'b0);
    load_ready = 1'b0;
    send_beat(16'h0044, 1'b0);
    send_beat(16'h0055, 1'b1);
    step();
    chk("arst_pre_cc", 32'(cell_count), 32'd1);
    chk("arst_pre_av", 32'(addr_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_av", 32'(addr_valid), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_cc", 32'(cell_count), 32'd0);
    step();
    rst = 1'b1;
    got.delete();
    load_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("arst_post_av[%0d]", i), 32'(addr_valid), 32'd0);
      chk($sformatf("arst_post_rdy[%0d]", i), 32'(in_ready), 32'd1);
    end
    chk("arst_no_delivery", 32'(got.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
